vga_scan_gen: RTL

//  Raster timing generator for the hourglass display; first stage of the pixel pipeline.

---
 rtl/hourglass_vga_pkg.sv | 42 ++++
 rtl/vga_scan_gen_pix_tick_div.sv | 34 +++
 rtl/vga_scan_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/hourglass_vga_pkg.sv
// Shared raster timing constants for the hourglass display pipeline.
// The raster generator, ball stages and sand stage all take their default
// geometry and coordinate width from here so they agree on the screen size.
package hourglass_vga_pkg;

  // Coordinate width used by every stage that handles a column or row value.
  localparam int COORD_W = 11;

  typedef logic [COORD_W-1:0] coord_t;

  // Default 640x480 @ 60 Hz timing, in pixels (horizontal) and lines (vertical).
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Inclusive sync windows for the default timing (656..751, 490..491).
  localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
  localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

  // Decoded per-position flags; levels here are "asserted" (1 = in window).
  typedef struct packed {
    logic video_on;
    logic hsync_act;
    logic vsync_act;
  } scan_flags_t;

  // True when v lies in the inclusive window [lo, hi].
  function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_scan_gen_pix_tick_div.sv
// Pixel-rate divider: produces a one-clock pix_tick strobe every CLK_DIV
// system clocks. The strobe is registered so downstream logic sees a clean
// enable that lines up with the clock edge that should advance the scan.
module pix_tick_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic BTN_S,
  output logic pix_tick
);

  // A 1-bit counter is kept for CLK_DIV=1 so the counter never has zero width;
  // it simply sits at 0 and the strobe is high every cycle.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // Free-running divider count and the registered strobe that follows its last state.
  always_ff @(posedge clk or posedge BTN_S) begin
    if (BTN_S) begin
      div_cnt  <= '0;
      pix_tick <= 1'b0;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      pix_tick <= (div_cnt == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_scan_gen.sv
// Raster timing generator: first stage of the hourglass pixel pipeline.
// Scans H_TOTAL x V_TOTAL positions at the pixel rate, drives hsync/vsync to
// the monitor, presents the current position and video_on to the shape and
// colour stages, and emits one frame_tick per frame for the sand animation.
// All flags are decoded from the next position and registered on the same
// edge as the counters, so they always describe the position shown with them.
module vga_scan_gen
  import hourglass_vga_pkg::*;
#(
  parameter int   CLK_DIV   = 2,
  parameter int   H_VISIBLE = DEF_H_VISIBLE,
  parameter int   H_FRONT   = DEF_H_FRONT,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BACK    = DEF_H_BACK,
  parameter int   V_VISIBLE = DEF_V_VISIBLE,
  parameter int   V_FRONT   = DEF_V_FRONT,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BACK    = DEF_V_BACK,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic               clk,
  input  logic               BTN_S,
  output logic               pix_tick,
  output logic [COORD_W-1:0] visible_col,
  output logic [COORD_W-1:0] visible_row,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_tick
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST       = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST       = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS        = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS        = coord_t'(V_VISIBLE);
  localparam coord_t H_SYNC_START = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t H_SYNC_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam coord_t V_SYNC_START = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t V_SYNC_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  // Reject geometries that cannot be counted in the coordinate width.
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_scan_gen: CLK_DIV must be at least 1");
  end
  if ((H_TOTAL >= (1 << COORD_W)) || (V_TOTAL >= (1 << COORD_W))) begin : g_bad_total
    $error("vga_scan_gen: raster totals must fit in COORD_W bits");
  end

  // Position decode: visible area and the asserted state of both sync windows.
  function automatic scan_flags_t decode_pos(input coord_t col, input coord_t row);
    scan_flags_t f;
    f.video_on  = (col < H_VIS) && (row < V_VIS);
    f.hsync_act = in_span(col, H_SYNC_START, H_SYNC_END);
    f.vsync_act = in_span(row, V_SYNC_START, V_SYNC_END);
    return f;
  endfunction

  // Map an asserted/deasserted sync state onto the monitor's line level.
  function automatic logic sync_level(input logic active);
    return active ? SYNC_POL : ~SYNC_POL;
  endfunction

  coord_t      col_nxt;
  coord_t      row_nxt;
  logic        frame_wrap;
  scan_flags_t flags_nxt;

  pix_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick_div (
    .clk      (clk),
    .BTN_S    (BTN_S),
    .pix_tick (pix_tick)
  );

  // Next position: advance one pixel per pix_tick, wrapping column then row.
  always_comb begin
    col_nxt    = visible_col;
    row_nxt    = visible_row;
    frame_wrap = 1'b0;
    if (pix_tick) begin
      if (visible_col == H_LAST) begin
        col_nxt = '0;
        if (visible_row == V_LAST) begin
          row_nxt    = '0;
          frame_wrap = 1'b1;
        end else begin
          row_nxt = visible_row + coord_t'(1);
        end
      end else begin
        col_nxt = visible_col + coord_t'(1);
      end
    end
  end

  // Flags for the position that will be on the outputs after this edge.
  always_comb begin
    flags_nxt = decode_pos(col_nxt, row_nxt);
  end

  // Stage boundary: position counters.
  always_ff @(posedge clk or posedge BTN_S) begin
    if (BTN_S) begin
      visible_col <= '0;
      visible_row <= '0;
    end else begin
      visible_col <= col_nxt;
      visible_row <= row_nxt;
    end
  end

  // Stage boundary: registered flags, updated every edge so they track the counters.
  always_ff @(posedge clk or posedge BTN_S) begin
    if (BTN_S) begin
      video_on <= 1'b0;
      hsync    <= ~SYNC_POL;
      vsync    <= ~SYNC_POL;
    end else begin
      video_on <= flags_nxt.video_on;
      hsync    <= sync_level(flags_nxt.hsync_act);
      vsync    <= sync_level(flags_nxt.vsync_act);
    end
  end

  // Stage boundary: one-clock frame pulse, high while (0,0) is first shown.
  always_ff @(posedge clk or posedge BTN_S) begin
    if (BTN_S) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_wrap;
    end
  end

endmodule
